layer_cfg_fetch: RTL and testbench
==================================

// Module: layer_cfg_fetch
// PURPOSE
//  Downstream consumer of the DDR image: after start, it reads per-layer config words from DDR over an AXI-style read port.
//  - Unpacks each word into layer fields and holds them (cfg_valid) until the array reports layer_done.
//  - Steps through layers 0..NumLay (NumLay taken from layer 0's word), then pulses all_done.
//  - Sits between the HP read port (S_HP_RD0) and the layer controller.
// PARAMETERS
//  PORT_DATAWIDTH  128  DDR word width in bits; byte stride per layer = PORT_DATAWIDTH/8
//  ADDR_WIDTH      32   byte address width
// PORTS
//  clk             in   1        clock
//  rst             in   1        async reset, active-high
//  start           in   1        1-cycle start pulse, sampled only in IDLE
//  cfg_base        in   ADDR_W   byte address of layer 0 config word, sampled on start
//  ar_valid        out  1        read address valid
//  ar_ready        in   1        read address ready
//  ar_addr         out  ADDR_W   cfg_base + layer_idx*(PORT_DATAWIDTH/8)
//  ar_len          out  8        burst length-1, constant 0
//  r_valid         in   1        read data valid
//  r_ready         out  1        read data ready, high only in WAIT
//  r_data          in   PDW      read data
//  r_last          in   1        last beat of burst
//  cfg_valid       out  1        fields below are valid for cfg_layer_idx
//  cfg_layer_idx   out  5        current layer number
//  cfg_lenrow, cfg_depblk, cfg_numblk  out  2 each   r_data[58:57], [56:55], [54:53]
//  cfg_numfrm      out  4        r_data[52:49]
//  cfg_numpat, cfg_numfilterg, cfg_numlay  out  5 each   [48:44], [43:39], [38:34]
//  cfg_pool        out  8        r_data[33:26]
//  cfg_fl          out  9        r_data[25:17]
//  cfg_valifm      out  8        r_data[16:9]
//  cfg_stride      out  9        r_data[8:0]
//  layer_done      in   1        layer finished; sampled only in HOLD
//  busy            out  1        state != IDLE
//  all_done        out  1        1-cycle pulse after the last layer's layer_done
//  cfg_err         out  1        sticky sanity error (only with LAYER_CFG_SANITY_EN)
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; layer_idx=0; total_lay=0; captured fields=0. Reset mid-burst: abandon the read, no replay.
//  FSM IDLE -> REQ -> WAIT -> HOLD -> (REQ | DONE) -> IDLE.
//  - IDLE: start=1 latches cfg_base, clears layer_idx/cfg_err; REQ next cycle. start outside IDLE is ignored.
//  - REQ: ar_valid=1. ar_addr stable until ar_valid&ar_ready, then WAIT.
//  - WAIT: r_ready=1.
//    - First accepted beat is captured; later beats are drained and discarded.
//    - Beat with r_last=1 -> HOLD. r_last on the first beat -> HOLD the cycle after that beat.
//  - HOLD: cfg_valid=1, fields stable.
//    - layer_idx 0 latches total_lay = r_data[38:34] on capture; later layers' NumLay fields are output only.
//    - layer_done with layer_idx==total_lay -> DONE. Otherwise layer_idx+1 -> REQ.
//  - DONE: all_done=1 for one cycle, cfg_valid=0, then IDLE.
//  - cfg_valid drops in the cycle after layer_done is accepted.
//  - Latency: start to cfg_valid = 3 cycles + ar_ready wait + r_valid wait.
//  - ar_addr arithmetic is modulo 2^ADDR_WIDTH (wraps). layer_idx is 5 bits; total_lay<=31, so no overflow.
//  - Bits [PDW-1:59] are ignored.
// CONFIGURATION
//  LAYER_CFG_SANITY_EN defined:
//  - Captured word with stride==0 or lenrow==0 sets sticky cfg_err.
//  - That layer skips HOLD: next layer is fetched directly, or DONE if it was the last. cfg_valid is never raised for it.
//  - Applies to layer 0 too; total_lay is still latched from layer 0.
//  Not defined: cfg_err tied 0 and every word enters HOLD.
// TESTING
//  1. cfg_base=0x1000, word0 = {2'd3,2'd2,2'd0,4'd15,5'd31,5'd1,5'd2,8'd15,9'd7,8'd7,9'd10}, ar_ready=1, r_valid next cycle
//     -> ar_addr=0x1000, then 0x1010, 0x1020. cfg_stride=10, cfg_numfilterg=1, cfg_lenrow=3.
//     -> Three layers; all_done pulse after the third layer_done.
//  2. ar_ready held 0 for 5 cycles -> ar_valid/ar_addr stable for 6 cycles; single handshake.
//  3. 3-beat burst, r_last on beat 3, beat 1 = word A -> fields = A; HOLD entered after beat 3.
//  4. start asserted in HOLD, and layer_done asserted in WAIT -> both ignored; layer_idx unchanged.
//  5. rst pulsed while in WAIT -> all outputs 0 asynchronously. New start refetches layer 0 at the new cfg_base.
//  6. LAYER_CFG_SANITY_EN, layer 1 stride=0, total_lay=2
//     -> cfg_err=1, no cfg_valid for layer 1, ar_addr=base+0x20 follows immediately.

Source files
------------

// File: rtl/layer_cfg_fetch.sv
// Layer config fetcher: reads one DDR config word per layer and holds the unpacked fields for the layer controller.
// Optional feature: define LAYER_CFG_SANITY_EN to flag (sticky cfg_err) and skip words with stride==0 or lenrow==0.
module layer_cfg_fetch #(
  parameter int PORT_DATAWIDTH = 128,
  parameter int ADDR_WIDTH     = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [ADDR_WIDTH-1:0]     cfg_base,
  output logic                      ar_valid,
  input  logic                      ar_ready,
  output logic [ADDR_WIDTH-1:0]     ar_addr,
  output logic [7:0]                ar_len,
  input  logic                      r_valid,
  output logic                      r_ready,
  input  logic [PORT_DATAWIDTH-1:0] r_data,
  input  logic                      r_last,
  output logic                      cfg_valid,
  output logic [4:0]                cfg_layer_idx,
  output logic [1:0]                cfg_lenrow,
  output logic [1:0]                cfg_depblk,
  output logic [1:0]                cfg_numblk,
  output logic [3:0]                cfg_numfrm,
  output logic [4:0]                cfg_numpat,
  output logic [4:0]                cfg_numfilterg,
  output logic [4:0]                cfg_numlay,
  output logic [7:0]                cfg_pool,
  output logic [8:0]                cfg_fl,
  output logic [7:0]                cfg_valifm,
  output logic [8:0]                cfg_stride,
  input  logic                      layer_done,
  output logic                      busy,
  output logic                      all_done,
  output logic                      cfg_err
);

  localparam int unsigned STRIDE_BYTES = PORT_DATAWIDTH / 8;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_DONE} state_t;

  state_t                r_state, w_next;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [4:0]            r_layer_idx;
  logic [4:0]            r_total;
  logic [58:0]           r_word;
  logic                  r_first;
  logic                  r_err;

  logic                  w_beat, w_cap, w_bad, w_last_layer, w_adv, w_unused;
  logic [58:0]           w_word;
  logic [4:0]            w_total;

  assign w_beat = (r_state == S_WAIT) && r_valid;
  assign w_cap  = w_beat && r_first;

  // Single-beat bursts decide on the beat being captured, so look through the capture register.
  assign w_word       = r_first ? r_data[58:0] : r_word;
  assign w_total      = (r_first && (r_layer_idx == 5'd0)) ? r_data[38:34] : r_total;
  assign w_last_layer = (r_layer_idx == w_total);

`ifdef LAYER_CFG_SANITY_EN
  assign w_bad = (w_word[8:0] == 9'd0) || (w_word[58:57] == 2'd0);
`else
  assign w_bad = 1'b0;
`endif

  assign w_unused = &{1'b0, r_data[PORT_DATAWIDTH-1:59]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_next = r_state;
    w_adv  = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_next = S_REQ;
      S_REQ:  if (ar_ready) w_next = S_WAIT;
      S_WAIT: begin
        if (r_valid && r_last) begin
          if (!w_bad)            w_next = S_HOLD;
          else if (w_last_layer) w_next = S_DONE;
          else begin
            w_next = S_REQ;
            w_adv  = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (layer_done) begin
          if (w_last_layer) w_next = S_DONE;
          else begin
            w_next = S_REQ;
            w_adv  = 1'b1;
          end
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every flop updates from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_base      <= '0;
      r_layer_idx <= '0;
      r_total     <= '0;
      r_word      <= '0;
      r_first     <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && start) begin
        r_base      <= cfg_base;
        r_layer_idx <= '0;
        r_err       <= 1'b0;
      end
      if ((r_state == S_REQ) && ar_ready) r_first <= 1'b1;
      if (w_cap) begin
        r_word  <= r_data[58:0];
        r_first <= 1'b0;
        if (r_layer_idx == 5'd0) r_total <= r_data[38:34];
        if (w_bad) r_err <= 1'b1;
      end
      if (w_adv) r_layer_idx <= r_layer_idx + 5'd1;
    end
  end

  assign ar_valid  = (r_state == S_REQ);
  assign r_ready   = (r_state == S_WAIT);
  assign cfg_valid = (r_state == S_HOLD);
  assign all_done  = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign ar_len    = 8'd0;
  assign ar_addr   = r_base + ADDR_WIDTH'(r_layer_idx) * ADDR_WIDTH'(STRIDE_BYTES);
  assign cfg_err   = r_err;

  assign cfg_layer_idx  = r_layer_idx;
  assign cfg_lenrow     = r_word[58:57];
  assign cfg_depblk     = r_word[56:55];
  assign cfg_numblk     = r_word[54:53];
  assign cfg_numfrm     = r_word[52:49];
  assign cfg_numpat     = r_word[48:44];
  assign cfg_numfilterg = r_word[43:39];
  assign cfg_numlay     = r_word[38:34];
  assign cfg_pool       = r_word[33:26];
  assign cfg_fl         = r_word[25:17];
  assign cfg_valifm     = r_word[16:9];
  assign cfg_stride     = r_word[8:0];

endmodule

// File: tb/tb_layer_cfg_fetch.sv
// Randomized bench for layer_cfg_fetch: a DDR slave plus layer controller driven from a layer-list model.
// Build with LAYER_CFG_SANITY_EN defined to exercise the bad-word skip path.
`timescale 1ns/1ps
module tb_layer_cfg_fetch;
  localparam int PDW   = 128;
  localparam int AW    = 32;
  localparam int BYTES = PDW / 8;

  logic           clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [AW-1:0]  cfg_base = '0;
  logic           ar_valid, ar_ready = 1'b0;
  logic [AW-1:0]  ar_addr;
  logic [7:0]     ar_len;
  logic           r_valid = 1'b0, r_ready, r_last = 1'b0;
  logic [PDW-1:0] r_data = '0;
  logic           cfg_valid;
  logic [4:0]     cfg_layer_idx;
  logic [1:0]     cfg_lenrow, cfg_depblk, cfg_numblk;
  logic [3:0]     cfg_numfrm;
  logic [4:0]     cfg_numpat, cfg_numfilterg, cfg_numlay;
  logic [7:0]     cfg_pool, cfg_valifm;
  logic [8:0]     cfg_fl, cfg_stride;
  logic           layer_done = 1'b0;
  logic           busy, all_done, cfg_err;
  logic [58:0]    fields;

  assign fields = {cfg_lenrow, cfg_depblk, cfg_numblk, cfg_numfrm, cfg_numpat, cfg_numfilterg,
                   cfg_numlay, cfg_pool, cfg_fl, cfg_valifm, cfg_stride};

  layer_cfg_fetch dut (
    .clk(clk), .rst(rst), .start(start), .cfg_base(cfg_base),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_len(ar_len),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_last(r_last),
    .cfg_valid(cfg_valid), .cfg_layer_idx(cfg_layer_idx),
    .cfg_lenrow(cfg_lenrow), .cfg_depblk(cfg_depblk), .cfg_numblk(cfg_numblk),
    .cfg_numfrm(cfg_numfrm), .cfg_numpat(cfg_numpat), .cfg_numfilterg(cfg_numfilterg),
    .cfg_numlay(cfg_numlay), .cfg_pool(cfg_pool), .cfg_fl(cfg_fl), .cfg_valifm(cfg_valifm),
    .cfg_stride(cfg_stride), .layer_done(layer_done), .busy(busy), .all_done(all_done),
    .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: the DDR image and the list of layers that must be held, in order.
  logic [PDW-1:0] words [32];
  logic [AW-1:0]  run_base;
  int             m_total, m_ngood;
  int             hold_list [32];

  int ar_pct = 100, rv_pct = 100, bmin = 1, bmax = 1, stall_first = 0, spur_pct = 20;
  bit start_req = 0, run_active = 0, rv = 0;
  bit exp_hold_next = 0, exp_skip_next = 0, exp_leave_next = 0, exp_idle_next = 0;
  int n_ar, n_hold, n_cap, pending, beat_no, burst_layer, stall, ar_wait, ld_delay;
  int done_cnt = 0, cyc = 0, start_cyc, first_cfg_lat;
  logic [58:0]   first_fields;
  logic [AW-1:0] addr_log [32];

  function automatic bit is_bad(input logic [PDW-1:0] w);
    return (w[8:0] == 9'd0) || (w[58:57] == 2'd0);
  endfunction

  function automatic bit holds(input logic [PDW-1:0] w);
`ifdef LAYER_CFG_SANITY_EN
    return !is_bad(w);
`else
    return 1'b1;
`endif
  endfunction

  function automatic bit exp_err(input int ncap);
`ifdef LAYER_CFG_SANITY_EN
    for (int i = 0; i < ncap; i++) if (is_bad(words[i])) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic logic [PDW-1:0] rand_word(input int numlay, input bit allow_bad);
    logic [PDW-1:0] w;
    w = {$urandom, $urandom, $urandom, $urandom};
    if (numlay >= 0) w[38:34] = 5'(numlay);
    if (w[8:0] == 9'd0) w[0] = 1'b1;
    if (w[58:57] == 2'd0) w[57] = 1'b1;
    if (allow_bad && ($urandom_range(0, 4) == 0)) begin
      if ($urandom_range(0, 1) == 1) w[8:0] = 9'd0;
      else w[58:57] = 2'd0;
    end
    return w;
  endfunction

  // Bus process: DDR slave, layer controller and per-cycle comparison against the model.
  initial begin : bus
    logic [AW-1:0] ea;
    int idx;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        run_active = 0; pending = 0; rv = 0; r_valid = 1'b0; r_last = 1'b0;
        layer_done = 1'b0; start = 1'b0; start_req = 0;
        exp_hold_next = 0; exp_skip_next = 0; exp_leave_next = 0; exp_idle_next = 0;
      end else begin
        if (ar_valid) begin
          ea = run_base + AW'(n_ar * BYTES);
          check("ar_addr", ar_addr, ea);
          check("ar_len", ar_len, 0);
          check("ar_in_range", n_ar <= m_total, 1);
        end
        if (exp_hold_next)  check("hold_entry", cfg_valid, 1);
        if (exp_skip_next)  check("skip_to_next", {cfg_valid, ar_valid | all_done}, 2'b01);
        if (exp_leave_next) check("hold_exit", {cfg_valid, ar_valid | all_done}, 2'b01);
        if (exp_idle_next)  check("idle_after_done", {busy, all_done}, 2'b00);
        exp_hold_next = 0; exp_skip_next = 0; exp_leave_next = 0; exp_idle_next = 0;
        if (cfg_valid) begin
          if (first_cfg_lat < 0) begin
            first_cfg_lat = cyc - start_cyc;
            first_fields  = fields;
          end
          check("cfg_valid_in_run", run_active, 1);
          check("hold_in_list", n_hold < m_ngood, 1);
          if (n_hold < m_ngood) begin
            idx = hold_list[n_hold];
            check("cfg_layer_idx", cfg_layer_idx, idx);
            check("cfg_fields", fields, words[idx][58:0]);
          end
          check("hold_no_beats_left", pending, 0);
          check("hold_busy", busy, 1);
        end
        if (run_active) check("cfg_err", cfg_err, exp_err(n_cap));
        if (all_done) begin
          check("done_ar_count", n_ar, m_total + 1);
          check("done_hold_count", n_hold, m_ngood);
          done_cnt++;
          run_active    = 0;
          exp_idle_next = 1;
        end

        // Start: requested run, or a spurious pulse while busy that must be ignored.
        start = 1'b0;
        if (start_req) begin
          start = 1'b1; cfg_base = run_base; start_req = 0; run_active = 1;
          n_ar = 0; n_hold = 0; n_cap = 0; pending = 0; rv = 0; stall = stall_first;
          ar_wait = 0; start_cyc = cyc; first_cfg_lat = -1; ld_delay = $urandom_range(0, 3);
        end else if (busy && ($urandom_range(0, 99) < spur_pct)) begin
          start = 1'b1; cfg_base = $urandom;
        end

        // Read data: valid held until accepted; only beat 0 carries the config word.
        if (pending > 0 && !rv && ($urandom_range(0, 99) < rv_pct)) begin
          rv     = 1;
          r_data = (beat_no == 0) ? words[burst_layer] : {$urandom, $urandom, $urandom, $urandom};
          r_last = (pending == 1);
        end
        r_valid = rv;
        if (rv && r_ready) begin
          if (beat_no == 0) n_cap++;
          if (pending == 1) begin
            if (holds(words[burst_layer])) exp_hold_next = 1;
            else exp_skip_next = 1;
          end
          pending--; beat_no++; rv = 0;
        end

        // Read address.
        if (ar_valid && n_ar == 0) ar_wait++;
        if (ar_valid && stall > 0) begin
          ar_ready = 1'b0;
          stall--;
        end else begin
          ar_ready = ($urandom_range(0, 99) < ar_pct);
        end
        if (ar_valid && ar_ready) begin
          if (n_ar < 32) addr_log[n_ar] = ar_addr;
          burst_layer = n_ar;
          n_ar++;
          pending = $urandom_range(bmin, bmax);
          beat_no = 0;
        end

        // Layer controller; layer_done outside HOLD must be ignored.
        layer_done = 1'b0;
        if (cfg_valid) begin
          if (ld_delay == 0) begin
            layer_done = 1'b1; n_hold++; exp_leave_next = 1; ld_delay = $urandom_range(0, 3);
          end else begin
            ld_delay--;
          end
        end else if ($urandom_range(0, 99) < spur_pct) begin
          layer_done = 1'b1;
        end
      end
    end
  end

  task automatic start_run(input logic [AW-1:0] base);
    m_total = int'(words[0][38:34]);
    m_ngood = 0;
    for (int i = 0; i <= m_total; i++) begin
      if (holds(words[i])) begin
        hold_list[m_ngood] = i;
        m_ngood++;
      end
    end
    run_base = base;
    @(posedge clk);
    #1 start_req = 1;
  endtask

  task automatic wait_run(input int budget);
    int k;
    k = 0;
    while ((run_active || start_req) && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    n_vec++;
    if (run_active || start_req) begin
      n_err++;
      $display("FAIL run_timeout: run still active after %0d cycles, expected all_done", k);
      #2 rst = 1'b1;
      @(negedge clk);
      #2 rst = 1'b0;
    end
  endtask

  initial begin : main
    logic [PDW-1:0] t1w;
    int d0, k, exp_holds, exp_e;
    #23;
    check("rst_ctrl", {ar_valid, r_ready, cfg_valid, busy, all_done, cfg_err}, 6'b0);
    check("rst_idx", cfg_layer_idx, 0);
    check("rst_fields", fields, 0);
    check("rst_addr", ar_addr, 0);
    check("rst_len", ar_len, 0);
    #4 rst = 1'b0;

    // Test 1: reference word, immediate handshakes, three layers.
    t1w = '0;
    t1w[58:0] = {2'd3, 2'd2, 2'd0, 4'd15, 5'd31, 5'd1, 5'd2, 8'd15, 9'd7, 8'd7, 9'd10};
    words[0] = t1w;
    words[1] = rand_word(-1, 0);
    words[2] = rand_word(-1, 0);
    ar_pct = 100; rv_pct = 100; bmin = 1; bmax = 1; spur_pct = 20;
    d0 = done_cnt;
    start_run(32'h0000_1000);
    wait_run(500);
    check("t1_addr0", addr_log[0], 32'h1000);
    check("t1_addr1", addr_log[1], 32'h1010);
    check("t1_addr2", addr_log[2], 32'h1020);
    check("t1_latency", first_cfg_lat, 3);
    check("t1_stride", first_fields[8:0], 10);
    check("t1_numfilterg", first_fields[43:39], 1);
    check("t1_lenrow", first_fields[58:57], 3);
    check("t1_fetches", n_ar, 3);
    check("t1_done_pulses", done_cnt, d0 + 1);

    // Test 2: ar_ready stalled for 5 cycles.
    words[0] = rand_word(0, 0);
    stall_first = 5;
    start_run($urandom);
    wait_run(500);
    stall_first = 0;
    check("t2_ar_valid_cycles", ar_wait, 6);
    check("t2_handshakes", n_ar, 1);

    // Test 3: 3-beat burst with layer_done and start asserted every cycle they must be ignored.
    t1w[38:34] = 5'd0;
    words[0] = t1w;
    bmin = 3; bmax = 3; spur_pct = 100;
    start_run(32'h0000_4000);
    wait_run(500);
    check("t3_latency", first_cfg_lat, 5);
    check("t3_stride", first_fields[8:0], 10);
    check("t3_pool", first_fields[33:26], 15);
    bmin = 1; bmax = 1; spur_pct = 20;

    // Test 5: reset while waiting for read data, then refetch at a new base.
    words[0] = rand_word(1, 0);
    words[1] = rand_word(-1, 0);
    rv_pct = 25; spur_pct = 0;
    start_run(32'h0000_5000);
    k = 0;
    do begin
      @(posedge clk);
      #2;
      k++;
    end while (!r_ready && k < 50);
    check("t5_reached_wait", r_ready, 1);
    #1 rst = 1'b1;
    #1;
    check("t5_rst_ctrl", {ar_valid, r_ready, cfg_valid, busy, all_done, cfg_err}, 6'b0);
    check("t5_rst_idx", cfg_layer_idx, 0);
    check("t5_rst_fields", fields, 0);
    check("t5_rst_addr", ar_addr, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    rv_pct = 100; spur_pct = 20;
    start_run(32'h0000_2000);
    wait_run(500);
    check("t5_refetch_addr0", addr_log[0], 32'h2000);
    check("t5_refetch_addr1", addr_log[1], 32'h2010);

    // Test 6: layer 1 has stride 0.
    words[0] = rand_word(2, 0);
    words[1] = rand_word(-1, 0);
    words[1][8:0] = 9'd0;
    words[2] = rand_word(-1, 0);
`ifdef LAYER_CFG_SANITY_EN
    exp_holds = 2; exp_e = 1;
`else
    exp_holds = 3; exp_e = 0;
`endif
    start_run(32'h0000_3000);
    wait_run(500);
    check("t6_addr1", addr_log[1], 32'h3010);
    check("t6_addr2", addr_log[2], 32'h3020);
    check("t6_holds", n_hold, exp_holds);
    check("t6_cfg_err", cfg_err, exp_e);

    // Randomized runs: random handshakes, burst lengths, bad words and wrapping bases.
    for (int r = 0; r < 40; r++) begin
      words[0] = rand_word($urandom_range(0, 4), 1);
      for (int i = 1; i < 32; i++) words[i] = rand_word(-1, 1);
      ar_pct = $urandom_range(40, 100);
      rv_pct = $urandom_range(40, 100);
      bmax = $urandom_range(1, 4);
      stall_first = $urandom_range(0, 3);
      d0 = done_cnt;
      start_run(($urandom_range(0, 3) == 0) ? 32'hFFFF_FFE0 : $urandom);
      wait_run(3000);
      check("rand_done_pulses", done_cnt, d0 + 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 900us");
    $fatal(1, "watchdog expired");
  end

endmodule
